// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: op encoding of {push, pop} and depth helper.
package stack_pkg;

    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    function automatic int unsigned depth(input int unsigned size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Control/status bundle between a datapath core (master) and the stack (slave).
interface stack_ctrl_if #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned SIZE  = 4
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [SIZE:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, asynchronous reads of top and top-1.
module stack_ram
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned SIZE  = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [SIZE-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SIZE-1:0]  raddr_top,
    input  logic [SIZE-1:0]  raddr_below,
    output logic [WIDTH-1:0] rdata_top,
    output logic [WIDTH-1:0] rdata_below
);
    localparam int unsigned Depth = depth(SIZE);

    logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_top   = mem[raddr_top];
    assign rdata_below = mem[raddr_below];
endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller: op decode, occupancy count, registered top-of-stack and flags.
// Define STACK_ERR_EN to generate the overflow/underflow pulses; otherwise they are tied low.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned SIZE  = 4
) (
    input logic         clk,
    input logic         reset,
    stack_ctrl_if.slave bus
);
    localparam int unsigned Depth  = depth(SIZE);
    localparam int unsigned CountW = SIZE + 1;

    logic [1:0]        op;
    logic [SIZE:0]     count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              full, empty;
    logic              we;
    logic [SIZE-1:0]   waddr;
    logic [SIZE-1:0]   top_addr, below_addr;
    logic [WIDTH-1:0]  rd_top, rd_below;

    assign op    = {bus.push, bus.pop};
    assign full  = (count_q == CountW'(Depth));
    assign empty = (count_q == '0);

    // Low SIZE bits wrap correctly for the top index even when count == Depth.
    assign top_addr   = count_q[SIZE-1:0] - SIZE'(1);
    assign below_addr = count_q[SIZE-1:0] - SIZE'(2);

    stack_ram #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_ram (
        .clk         (clk),
        .we          (we),
        .waddr       (waddr),
        .wdata       (bus.data_in),
        .raddr_top   (top_addr),
        .raddr_below (below_addr),
        .rdata_top   (rd_top),
        .rdata_below (rd_below)
    );

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        we      = 1'b0;
        waddr   = count_q[SIZE-1:0];
        unique case (op)
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                    dout_d  = bus.data_in;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    count_d = count_q - 1'b1;
                    dout_d  = (count_q == CountW'(1)) ? '0 : rd_below;
                end
            end
            OP_REPLACE: begin
                we     = 1'b1;
                dout_d = bus.data_in;
                if (empty) begin
                    count_d = CountW'(1);
                end else begin
                    waddr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

`ifdef STACK_ERR_EN
    logic push_rej, pop_rej;
    logic ovf_q, unf_q;

    assign push_rej = (op == OP_PUSH) && full;
    assign pop_rej  = (op == OP_POP) && empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= push_rej;
            unf_q <= pop_rej;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.data_out = dout_q;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.empty    = empty;

    // The registered top must always mirror the live top entry in storage.
    top_matches_ram : assert property (@(posedge clk) disable iff (reset)
        !empty |-> (dout_q == rd_top));
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed table-driven bench for stack_ctrl with WIDTH=18, SIZE=2 (depth 4).
module tb_stack_ctrl;
    localparam int unsigned WIDTH = 18;
    localparam int unsigned SIZE  = 2;
`ifdef STACK_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        logic             reset;
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_dout;
        logic [SIZE:0]    exp_count;
        logic             exp_ovf;
        logic             exp_unf;
    } vec_t;

    logic clk;
    logic reset;

    stack_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    stack_ctrl #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] dout,
                                input logic [SIZE:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.reset     = r;
        v.push      = pu;
        v.pop       = po;
        v.din       = din;
        v.exp_dout  = dout;
        v.exp_count = cnt;
        v.exp_ovf   = ovf;
        v.exp_unf   = unf;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic             e_full, e_empty, e_ovf, e_unf;
        reset       = v.reset;
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.data_in = v.din;
        @(posedge clk);
        #1;
        e_full  = (v.exp_count == 3'd4);
        e_empty = (v.exp_count == 3'd0);
        e_ovf   = v.exp_ovf & ErrEn;
        e_unf   = v.exp_unf & ErrEn;
        n_vec++;
        if (bus.data_out !== v.exp_dout || bus.count !== v.exp_count ||
            bus.full !== e_full || bus.empty !== e_empty ||
            bus.overflow !== e_ovf || bus.underflow !== e_unf) begin
            n_err++;
            $display("FAIL %s[%0d]: got dout=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want dout=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                     tag, idx, bus.data_out, bus.count, bus.full, bus.empty,
                     bus.overflow, bus.underflow, v.exp_dout, v.exp_count,
                     e_full, e_empty, e_ovf, e_unf);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;

        //                 rst  push pop  din       dout      cnt   ovf  unf
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h15555, 18'h15555, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h2AAAA, 18'h2AAAA, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h04444, 18'h04444, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h3BBBB, 18'h3BBBB, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h3C3C3, 18'h3BBBB, 3'd4, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 18'h00000, 18'h3BBBB, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h04444, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h2AAAA, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h15555, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h00001, 18'h00001, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h00002, 18'h00002, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 18'h00003, 18'h00003, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00001, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 18'h12345, 18'h12345, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h11111, 18'h11111, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h22222, 18'h22222, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 18'h33333, 18'h00000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h0AAAA, 18'h0AAAA, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 18'h0BBBB, 18'h0BBBB, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h0AAAA, 3'd1, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            apply(tbl[i], "tbl", i);
        end

        // Fill, two rejected pushes in a row, replace while full, then drain past empty.
        apply(mk(1'b0, 1'b1, 1'b0, 18'h00011, 18'h00011, 3'd2, 1'b0, 1'b0), "seq_full", 0);
        apply(mk(1'b0, 1'b1, 1'b0, 18'h00022, 18'h00022, 3'd3, 1'b0, 1'b0), "seq_full", 1);
        apply(mk(1'b0, 1'b1, 1'b0, 18'h00033, 18'h00033, 3'd4, 1'b0, 1'b0), "seq_full", 2);
        apply(mk(1'b0, 1'b1, 1'b0, 18'h00044, 18'h00033, 3'd4, 1'b1, 1'b0), "seq_full", 3);
        apply(mk(1'b0, 1'b1, 1'b0, 18'h00055, 18'h00033, 3'd4, 1'b1, 1'b0), "seq_full", 4);
        apply(mk(1'b0, 1'b1, 1'b1, 18'h00066, 18'h00066, 3'd4, 1'b0, 1'b0), "seq_full", 5);
        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00022, 3'd3, 1'b0, 1'b0), "seq_full", 6);

        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00011, 3'd2, 1'b0, 1'b0), "seq_empty", 0);
        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h0AAAA, 3'd1, 1'b0, 1'b0), "seq_empty", 1);
        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0), "seq_empty", 2);
        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b1), "seq_empty", 3);
        apply(mk(1'b0, 1'b0, 1'b1, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b1), "seq_empty", 4);
        apply(mk(1'b0, 1'b0, 1'b0, 18'h00000, 18'h00000, 3'd0, 1'b0, 1'b0), "seq_empty", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
